ram_arb: RTL and testbench
==========================

// Module: ram_arb
// PURPOSE
//  Two-port round-robin arbiter sharing one ram instance between the instruction-fetch
//  master (M0) and the load/store master (M1). It accepts one request at a time
//  over a valid/ready handshake and drives the ram read or write port for exactly one cycle.
//  It returns a registered response to the owning master. It sits between the core
//  front/back ends and the ram.
// PARAMETERS
//  ADDR_W   `ADDR_WIDTH      byte-address width of requests and ram ports
//  DATA_W   `DATA_WIDTH (32) data width; mask width = DATA_W/8
// PORTS
//  i_sys_clk          in   1         system clock, all state on rising edge
//  i_sys_rst_n        in   1         async active-low reset
//  i_mN_req_valid     in   1         master N (N=0,1) request valid
//  o_mN_req_ready     out  1         master N request accepted this cycle
//  i_mN_req_we        in   1         1 = write, 0 = read
//  i_mN_req_addr      in   ADDR_W    byte address (passed unmodified to ram)
//  i_mN_req_wdata     in   DATA_W    write data
//  i_mN_req_wmask     in   DATA_W/8  byte write mask
//  o_mN_resp_valid    out  1         response for master N valid
//  i_mN_resp_ready    in   1         master N consumes response
//  o_mN_resp_rdata    out  DATA_W    read data (zero for writes)
//  o_ram_rd_en/o_ram_rd_addr         out 1/ADDR_W    to ram read port
//  i_ram_rd_data      in   DATA_W    ram combinational read data
//  o_ram_wr_en/o_ram_wr_addr/o_ram_wr_data/o_ram_wr_mask  out 1/ADDR_W/DATA_W/DATA_W/8
// BEHAVIOUR
//  - Reset: FSM=IDLE, prio pointer=M0, all outputs 0, captured request regs 0.
//  - FSM IDLE: o_mN_req_ready is combinational. It goes high only for the winner,
//    only in IDLE, and only when that master's valid is high. On handshake, the
//    request {we,addr,wdata,wmask} and owner are captured; next state = ACCESS.
//  - Arbitration: if only one master is valid, that master wins. If both are valid,
//    the prio pointer wins. After every grant, the pointer moves to the non-granted master.
//  - ACCESS (1 cycle): ram driven from captured regs only.
//    - Read: o_ram_rd_en=1; i_ram_rd_data is registered into resp_rdata.
//    - Write: o_ram_wr_en=1 with the captured mask; resp_rdata=0.
//    - Next state = RESP.
//  - RESP: o_mOwner_resp_valid=1 with stable rdata. On resp_ready, next state = IDLE.
//    While resp_ready is low, the block stalls and holds all outputs.
//  - Latency: accept at T, ram access at T+1, resp_valid at T+2. Throughput is at
//    most 1 transaction per 3 cycles when resp_ready is held high.
//  - Outside ACCESS, o_ram_rd_en=o_ram_wr_en=0. Ram address/data outputs hold the
//    captured values (no glitching to masters' live inputs).
//  - wmask=0 write: a ram write cycle is still issued with mask 0, so no bytes change;
//    a response is still returned.
//  - Valid dropped without ready: no effect. A non-winner's valid may stay high
//    across transactions without being lost.
//  - The non-owner's resp_valid is always 0. resp_ready from the non-owner is ignored.
//  - Reset asserted mid-ACCESS or mid-RESP: the FSM returns to IDLE and no
//    wr_en/resp_valid is issued afterwards. The in-flight transaction is dropped.
//  - No address range checking. The ram applies its own base offset and word indexing.
// STRUCTURE
//  - Package ram_arb_pkg: typedef enum logic[1:0] {IDLE,ACCESS,RESP} arb_state_e;
//    typedef struct packed {we,addr,wdata,wmask} mem_req_t; localparam NUM_MST=2.
//  - One sub-module: rr_arb2, a 2-way round-robin grant with pointer update on an
//    accept pulse. The rest (FSM, capture regs, response regs) is flat.
// TESTING
//  - Reset mid-write: assert i_sys_rst_n=0 during ACCESS -> all outputs 0 immediately;
//    no further wr_en; next request works normally.
//  - M0 read 0x8000_0000 only, ram word=0xDEADBEEF -> ready@T, rd_en@T+1 with addr
//    0x8000_0000, m0_resp_valid@T+2 rdata=0xDEADBEEF; m1 outputs stay 0.
//  - M1 write 0x8000_0010 data 0x11223344 mask 4'b0101 -> wr_en for one cycle with
//    mask 0101; readback returns 0x??22??44 with the old bytes kept; resp rdata=0.
//  - Both valid continuously for 6 transactions -> grants alternate M0,M1,M0,M1...
//    and neither master starves.
//  - M0 resp_ready held low 5 cycles -> resp_valid/rdata stable. M1 valid is not
//    accepted until the cycle after the M0 resp handshake.
//  - wmask=0 write to 0x8000_0004 -> wr_en pulses with mask 0; memory unchanged;
//    response returned.

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_arb_pkg
// Purpose : Shared types and constants for the two-master ram arbiter.
//           Holds the bus widths, the master count, the arbiter FSM state
//           encoding and the packed request record captured on a grant.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package ram_arb_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int NUM_MST    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] wmask;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/ram_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : ram_arb_if
// Purpose : Request/response channel between one master and the arbiter.
// Ports   : req_valid/req_ready handshake with req_we, req_addr, req_wdata,
//           req_wmask; resp_valid/resp_ready handshake with resp_rdata.
//           modport master : the requesting core side
//           modport slave  : the arbiter side
// Revision: 1.0  initial release
// ============================================================================
interface ram_arb_if;
  import ram_arb_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [MASK_WIDTH-1:0] req_wmask;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface
`default_nettype wire

// File: rtl/ram_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Purpose : Two-way round-robin grant. A lone requester always wins; on a
//           tie the priority pointer wins. On each accept pulse the pointer
//           moves to the master that was not granted.
// Ports   : clk, rst_n (async active-low)
//           req[1:0]   request vector (bit N = master N)
//           accept     the current grant was taken
//           grant[1:0] one-hot grant (all zero when nobody requests)
// Revision: 1.0  initial release
// ============================================================================
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_MST-1:0] req,
  input  logic               accept,
  output logic [NUM_MST-1:0] grant
);

  logic ptr;  // 0 = M0 has priority on a tie

  always_comb begin
    grant = '0;
    if (req[0] && req[1]) begin
      grant[ptr] = 1'b1;
    end else begin
      grant = req;
    end
  end

  // Winner M1 -> pointer to M0 (0); winner M0 -> pointer to M1 (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arb.sv
`default_nettype none
// ============================================================================
// Module  : ram_arb
// Purpose : Shares one ram between the instruction-fetch master (m0) and
//           the load/store master (m1). One request at a time: accept in
//           IDLE, drive the ram for exactly one ACCESS cycle, then hold a
//           registered response in RESP until the owner takes it.
// Ports   : clk, rst_n           clock, async active-low reset
//           m0, m1               ram_arb_if.slave request/response channels
//           ram_rd_en/addr/data  ram read port (read data combinational)
//           ram_wr_en/addr/data/mask  ram write port
// Revision: 1.0  initial release
// ============================================================================
module ram_arb
  import ram_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  ram_arb_if.slave              m0,
  ram_arb_if.slave              m1,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [MASK_WIDTH-1:0] ram_wr_mask
);

  arb_state_e            state;
  mem_req_t              cap;         // request captured at the grant
  mem_req_t              cand;        // request of the current winner
  logic                  owner;       // 0 = m0, 1 = m1
  logic [DATA_WIDTH-1:0] rdata;
  logic [NUM_MST-1:0]    resp_valid;
  logic                  rd_en;
  logic                  wr_en;
  logic [NUM_MST-1:0]    req_vec;
  logic [NUM_MST-1:0]    grant;
  logic                  accept;
  logic                  own_resp_ready;

  assign req_vec = {m1.req_valid, m0.req_valid};

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_vec),
    .accept (accept),
    .grant  (grant)
  );

  // Ready only in IDLE; grant is already qualified by the master's valid.
  assign m0.req_ready = (state == IDLE) && grant[0];
  assign m1.req_ready = (state == IDLE) && grant[1];
  assign accept       = (state == IDLE) && (|grant);

  always_comb begin
    cand = '0;
    if (grant[1]) begin
      cand.we    = m1.req_we;
      cand.addr  = m1.req_addr;
      cand.wdata = m1.req_wdata;
      cand.wmask = m1.req_wmask;
    end else begin
      cand.we    = m0.req_we;
      cand.addr  = m0.req_addr;
      cand.wdata = m0.req_wdata;
      cand.wmask = m0.req_wmask;
    end
  end

  // The non-owner's resp_ready is never looked at.
  assign own_resp_ready = owner ? m1.resp_ready : m0.resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cap        <= '0;
      owner      <= 1'b0;
      rdata      <= '0;
      rd_en      <= 1'b0;
      wr_en      <= 1'b0;
      resp_valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap   <= cand;
            owner <= grant[1];
            rd_en <= ~cand.we;
            wr_en <= cand.we;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          rd_en             <= 1'b0;
          wr_en             <= 1'b0;
          rdata             <= cap.we ? '0 : ram_rd_data;
          resp_valid[owner] <= 1'b1;
          state             <= RESP;
        end
        RESP: begin
          if (own_resp_ready) begin
            resp_valid <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ram address/data always reflect the captured request, never live inputs.
  assign ram_rd_en   = rd_en;
  assign ram_wr_en   = wr_en;
  assign ram_rd_addr = cap.addr;
  assign ram_wr_addr = cap.addr;
  assign ram_wr_data = cap.wdata;
  assign ram_wr_mask = cap.wmask;

  assign m0.resp_valid = resp_valid[0];
  assign m1.resp_valid = resp_valid[1];
  assign m0.resp_rdata = owner ? '0 : rdata;
  assign m1.resp_rdata = owner ? rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_arb
// Purpose : Directed self-checking bench for ram_arb with a small byte-mask
//           ram model (16 words, indexed by addr[5:2]).
// Ports   : none
// Revision: 1.0  initial release
// ============================================================================
module tb_ram_arb;
  import ram_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ram_rd_en;
  logic [31:0] ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic        ram_wr_en;
  logic [31:0] ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic [3:0]  ram_wr_mask;

  int checks = 0;
  int errors = 0;

  ram_arb_if m0_if ();
  ram_arb_if m1_if ();

  ram_arb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0          (m0_if),
    .m1          (m1_if),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr_mask (ram_wr_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ram model
  logic [31:0] mem [16];
  logic        mem_init;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'hDEAD_BEEF;
      1:       return 32'h5566_7788;
      2:       return 32'h0BAD_F00D;
      4:       return 32'hAABB_CCDD;
      default: return 32'h0101_0101 * i;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (ram_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_wr_mask[b]) mem[ram_wr_addr[5:2]][8*b +: 8] <= ram_wr_data[8*b +: 8];
    end
  end

  assign ram_rd_data = mem[ram_rd_addr[5:2]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int mst, input logic v, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask);
    if (mst == 0) begin
      m0_if.req_valid = v; m0_if.req_we = we; m0_if.req_addr = addr;
      m0_if.req_wdata = wdata; m0_if.req_wmask = wmask;
    end else begin
      m1_if.req_valid = v; m1_if.req_we = we; m1_if.req_addr = addr;
      m1_if.req_wdata = wdata; m1_if.req_wmask = wmask;
    end
  endtask

  function automatic logic rdy(input int mst);
    return (mst == 0) ? m0_if.req_ready : m1_if.req_ready;
  endfunction

  function automatic logic rvld(input int mst);
    return (mst == 0) ? m0_if.resp_valid : m1_if.resp_valid;
  endfunction

  function automatic logic [31:0] rdat(input int mst);
    return (mst == 0) ? m0_if.resp_rdata : m1_if.resp_rdata;
  endfunction

  // One complete transaction from IDLE; both resp_ready assumed high.
  task automatic do_txn(input int mst, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input logic [31:0] exp_rdata);
    drive(mst, 1'b1, we, addr, wdata, wmask);
    @(negedge clk);
    chk("req_ready owner", rdy(mst), 1);
    chk("req_ready other", rdy(1 - mst), 0);
    tick();
    // Scramble the live inputs: ram must keep the captured request.
    drive(mst, 1'b0, ~we, 32'hFFFF_FFFC, 32'h0, 4'hF);
    @(negedge clk);
    chk("access rd_en", ram_rd_en, !we);
    chk("access wr_en", ram_wr_en, we);
    chk("access addr", we ? ram_wr_addr : ram_rd_addr, addr);
    if (we) begin
      chk("access wr_data", ram_wr_data, wdata);
      chk("access wr_mask", ram_wr_mask, wmask);
    end
    chk("access resp_valid", {m1_if.resp_valid, m0_if.resp_valid}, 0);
    tick();
    @(negedge clk);
    chk("resp ram idle", {ram_rd_en, ram_wr_en}, 0);
    chk("resp_valid owner", rvld(mst), 1);
    chk("resp_valid other", rvld(1 - mst), 0);
    chk("resp rdata", rdat(mst), exp_rdata);
    chk("resp rdata other", rdat(1 - mst), 0);
    tick();
    @(negedge clk);
    chk("resp_valid cleared", rvld(mst), 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    mem_init = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    m0_if.resp_ready = 1'b1;
    m1_if.resp_ready = 1'b1;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("reset rd_en", ram_rd_en, 0);
    chk("reset wr_en", ram_wr_en, 0);
    chk("reset addr", ram_rd_addr, 0);
    chk("reset wr_data", ram_wr_data, 0);
    chk("reset resp_valid", {m1_if.resp_valid, m0_if.resp_valid}, 0);
    chk("reset rdata", {m1_if.resp_rdata, m0_if.resp_rdata}, 0);
    tick();
    rst_n    = 1'b1;
    mem_init = 1'b0;
    tick();

    // M0 read, M1 idle
    do_txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF);

    // M1 partial write, then read back through M0
    do_txn(1, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 32'h0);
    chk("mem after mask write", mem[4], 32'hAA22_CC44);
    do_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hAA22_CC44);

    // Both masters valid: pointer now favours M1, grants must alternate
    drive(0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      logic e1;
      e1 = (i % 2 == 0);
      @(negedge clk);
      chk("rr ready m0", m0_if.req_ready, !e1);
      chk("rr ready m1", m1_if.req_ready, e1);
      tick();
      @(negedge clk);
      chk("rr rd_addr", ram_rd_addr, e1 ? 32'h8000_0004 : 32'h8000_0000);
      tick();
      @(negedge clk);
      chk("rr resp_valid", {m1_if.resp_valid, m0_if.resp_valid}, e1 ? 2'b10 : 2'b01);
      chk("rr rdata", e1 ? m1_if.resp_rdata : m0_if.resp_rdata,
          e1 ? 32'h5566_7788 : 32'hDEAD_BEEF);
      tick();
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();

    // M0 response stalled 5 cycles while M1 waits
    m0_if.resp_ready = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
    @(negedge clk);
    chk("stall m0 ready", m0_if.req_ready, 1);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    @(negedge clk);
    chk("stall m1 ready in access", m1_if.req_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall resp_valid", m0_if.resp_valid, 1);
      chk("stall rdata", m0_if.resp_rdata, 32'hAA22_CC44);
      chk("stall m1 ready", m1_if.req_ready, 0);
      chk("stall m1 resp_valid", m1_if.resp_valid, 0);
      tick();
    end
    m0_if.resp_ready = 1'b1;
    @(negedge clk);
    chk("handshake m1 ready", m1_if.req_ready, 0);
    tick();
    do_txn(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF);

    // Zero-mask write still issues a ram cycle and a response
    do_txn(0, 1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'h0, 32'h0);
    chk("mem after zero mask", mem[1], 32'h5566_7788);
    do_txn(1, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'h5566_7788);

    // Reset asserted during a write ACCESS
    drive(1, 1'b1, 1'b1, 32'h8000_0008, 32'h0000_0000, 4'hF);
    @(negedge clk);
    chk("rst test accept", m1_if.req_ready, 1);
    tick();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("rst test wr_en before", ram_wr_en, 1);
    rst_n = 1'b0;
    #1;
    chk("rst wr_en", ram_wr_en, 0);
    chk("rst wr_addr", ram_wr_addr, 0);
    chk("rst wr_mask", ram_wr_mask, 0);
    chk("rst rd_en", ram_rd_en, 0);
    chk("rst resp_valid", {m1_if.resp_valid, m0_if.resp_valid}, 0);
    tick();
    @(negedge clk);
    chk("rst hold wr_en", ram_wr_en, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst wr_en", ram_wr_en, 0);
    chk("post rst resp_valid", {m1_if.resp_valid, m0_if.resp_valid}, 0);
    chk("mem after dropped write", mem[2], 32'h0BAD_F00D);
    tick();
    do_txn(0, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
